// File: rtl/sram_b_fifo_ctrl.sv
// sram_b_fifo_ctrl: streaming valid/ready queue built on an external 1w:1r SRAM
//   (2^DEPTH_LOG2 x WIDTH, 1-cycle read latency). A 2-entry output buffer hides
//   the read latency. Push-to-OUT_VALID latency is 3 cycles, throughput 1 word/cycle.
//   IN_READY drops once the SRAM holds DEPTH words. The output buffer is sized so
//   that it never overflows: a fetch is only issued when a buffer slot is free.
// Ports:
//   CLK/RSTN/CLR                          clock, async active-low reset, sync flush
//   IN_VALID/IN_READY/IN_DATA             producer side
//   OUT_VALID/OUT_READY/OUT_DATA          consumer side
//   COUNT                                 words held (SRAM + in-flight read + buffer)
//   MEM_CE0/A0/D0/WE0/WEM0                SRAM write port
//   MEM_CE1/A1, MEM_Q1                    SRAM read port and returning data
module sram_b_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 13,
    parameter int WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CLR,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WIDTH-1:0]      IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [WIDTH-1:0]      OUT_DATA,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  MEM_CE0,
    output logic [DEPTH_LOG2-1:0] MEM_A0,
    output logic [WIDTH-1:0]      MEM_D0,
    output logic                  MEM_WE0,
    output logic [WIDTH-1:0]      MEM_WEM0,
    output logic                  MEM_CE1,
    output logic [DEPTH_LOG2-1:0] MEM_A1,
    input  logic [WIDTH-1:0]      MEM_Q1
);

    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d;
    logic [WIDTH-1:0]      ob0_q, ob0_d;   // head of output buffer
    logic [WIDTH-1:0]      ob1_q, ob1_d;

    logic       push;
    logic       pop;
    logic       fetch;
    logic       capture;
    logic [2:0] ob_occ;
    logic [1:0] tail;

    always_comb begin
        IN_READY  = RSTN & ~CLR & (mem_cnt_q != DEPTH);
        OUT_VALID = (ob_cnt_q != 2'd0);
        OUT_DATA  = ob0_q;
        push      = IN_VALID & IN_READY;
        pop       = OUT_VALID & OUT_READY;
        // Buffer slots committed after this cycle: held + in flight - leaving.
        ob_occ    = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        fetch     = (mem_cnt_q != '0) & ~CLR & (ob_occ < 3'd2);
        // A flush kills the read in flight: its data is dropped here.
        capture   = rd_pend_q & ~CLR;
        tail      = ob_cnt_q - {1'b0, pop};

        COUNT = mem_cnt_q + {{DEPTH_LOG2{1'b0}}, rd_pend_q}
                          + {{(DEPTH_LOG2-1){1'b0}}, ob_cnt_q};

        MEM_CE0  = push;
        MEM_WE0  = push;
        MEM_WEM0 = {WIDTH{push}};
        MEM_A0   = push ? wptr_q : '0;
        MEM_D0   = push ? IN_DATA : '0;
        MEM_CE1  = fetch;
        MEM_A1   = fetch ? rptr_q : '0;

        wptr_d    = wptr_q + {{(DEPTH_LOG2-1){1'b0}}, push};
        rptr_d    = rptr_q + {{(DEPTH_LOG2-1){1'b0}}, fetch};
        mem_cnt_d = mem_cnt_q + {{DEPTH_LOG2{1'b0}}, push}
                              - {{DEPTH_LOG2{1'b0}}, fetch};
        rd_pend_d = fetch;
        ob_cnt_d  = ob_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};

        // Output buffer is a 2-deep shift register: pop shifts toward the head,
        // capture lands in the first free slot after that shift.
        ob0_d = ob0_q;
        ob1_d = ob1_q;
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (capture) begin
            if (tail == 2'd0) begin
                ob0_d = MEM_Q1;
            end else begin
                ob1_d = MEM_Q1;
            end
        end

        if (CLR) begin
            wptr_d    = '0;
            rptr_d    = '0;
            mem_cnt_d = '0;
            rd_pend_d = 1'b0;
            ob_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
            ob_cnt_q  <= ob_cnt_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

endmodule

// File: tb/tb_sram_b_fifo_ctrl.sv
// tb_sram_b_fifo_ctrl: directed bench for sram_b_fifo_ctrl with a behavioural
//   8192x8 SRAM (1-cycle read latency). Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
module tb_sram_b_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CLR;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_DATA;
    logic [13:0] COUNT;
    logic        MEM_CE0;
    logic [12:0] MEM_A0;
    logic [7:0]  MEM_D0;
    logic        MEM_WE0;
    logic [7:0]  MEM_WEM0;
    logic        MEM_CE1;
    logic [12:0] MEM_A1;
    logic [7:0]  MEM_Q1;

    int n_tests = 0;
    int n_fail  = 0;

    sram_b_fifo_ctrl #(.DEPTH_LOG2(13), .WIDTH(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .COUNT(COUNT),
        .MEM_CE0(MEM_CE0), .MEM_A0(MEM_A0), .MEM_D0(MEM_D0),
        .MEM_WE0(MEM_WE0), .MEM_WEM0(MEM_WEM0),
        .MEM_CE1(MEM_CE1), .MEM_A1(MEM_A1), .MEM_Q1(MEM_Q1)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: masked write, registered read.
    logic [7:0] sram [0:8191];
    always @(posedge CLK) begin
        if (MEM_CE0 && MEM_WE0)
            sram[MEM_A0] <= (sram[MEM_A0] & ~MEM_WEM0) | (MEM_D0 & MEM_WEM0);
        if (MEM_CE1)
            MEM_Q1 <= sram[MEM_A1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        int k, popped, aerr, derr, rerr, rd_exp, sent, recv;
        int cerr, colerr, uerr;
        logic [12:0] last_a0;
        logic [7:0]  expd;
        logic [7:0]  sb[$];

        // ---------------- reset ----------------
        RSTN = 1'b0; CLR = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'hFF; OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        mid();
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_ce0", MEM_CE0, 0);
        chk("rst_we0", MEM_WE0, 0);
        chk("rst_ce1", MEM_CE1, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_count", COUNT, 0);
        RSTN = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        step();
        mid();
        chk("post_rst_in_ready", IN_READY, 1);
        chk("post_rst_count", COUNT, 0);
        step();

        // ---------------- single word ----------------
        IN_VALID = 1'b1; IN_DATA = 8'hA5;
        mid();
        chk("sw_ce0", MEM_CE0, 1);
        chk("sw_we0", MEM_WE0, 1);
        chk("sw_wem0", MEM_WEM0, 8'hFF);
        chk("sw_a0", MEM_A0, 0);
        chk("sw_d0", MEM_D0, 8'hA5);
        step();
        IN_VALID = 1'b0;
        mid();
        chk("sw_c1_ce1", MEM_CE1, 1);
        chk("sw_c1_a1", MEM_A1, 0);
        chk("sw_c1_count", COUNT, 1);
        chk("sw_c1_ovld", OUT_VALID, 0);
        step();
        mid();
        chk("sw_c2_ce1", MEM_CE1, 0);
        chk("sw_c2_ovld", OUT_VALID, 0);
        chk("sw_c2_count", COUNT, 1);
        step();
        OUT_READY = 1'b1;
        mid();
        chk("sw_c3_ovld", OUT_VALID, 1);
        chk("sw_c3_odata", OUT_DATA, 8'hA5);
        step();
        OUT_READY = 1'b0;
        mid();
        chk("sw_after_pop_count", COUNT, 0);
        chk("sw_after_pop_ovld", OUT_VALID, 0);
        step();

        // ---------------- fill and wrap ----------------
        // Pointers sit at 1 after the single-word test, so fill addresses start at 1.
        k = 0; aerr = 0; last_a0 = '0;
        IN_VALID = 1'b1;
        for (int c = 0; c < 8300; c++) begin
            IN_DATA = k[7:0];
            mid();
            if (IN_READY) begin
                if (MEM_A0 !== 13'(k + 1)) aerr++;
                last_a0 = MEM_A0;
                k++;
            end
            step();
        end
        IN_VALID = 1'b0;
        mid();
        chk("fill_accepted", k, 8194);
        chk("fill_addr_errs", aerr, 0);
        chk("fill_last_a0", last_a0, 13'd2);
        chk("fill_count", COUNT, 8194);
        chk("fill_in_ready", IN_READY, 0);
        chk("fill_head", OUT_DATA, 8'h00);
        step();

        popped = 0; derr = 0; rerr = 0; rd_exp = 3;
        OUT_READY = 1'b1;
        for (int c = 0; c < 8400; c++) begin
            mid();
            if (MEM_CE1) begin
                if (MEM_A1 !== 13'(rd_exp)) rerr++;
                rd_exp++;
            end
            if (OUT_VALID) begin
                if (OUT_DATA !== popped[7:0]) derr++;
                popped++;
            end
            step();
        end
        mid();
        chk("drain_popped", popped, 8194);
        chk("drain_data_errs", derr, 0);
        chk("drain_raddr_errs", rerr, 0);
        chk("drain_reads", rd_exp, 8195);
        chk("drain_count", COUNT, 0);
        chk("drain_ovld", OUT_VALID, 0);
        step();

        // ---------------- streaming ----------------
        sent = 0; recv = 0;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int c = 0; c < 60; c++) begin
            IN_DATA = sent[7:0] ^ 8'h5A;
            mid();
            if (c < 3) begin
                chk("stream_warmup_ovld", OUT_VALID, 0);
            end else begin
                expd = recv[7:0] ^ 8'h5A;
                chk("stream_ovld", OUT_VALID, 1);
                chk("stream_count", COUNT, 3);
                chk("stream_data", OUT_DATA, expd);
            end
            if (IN_READY) sent++;
            if (OUT_VALID) recv++;
            step();
        end
        IN_VALID = 1'b0;
        for (int c = 0; c < 10; c++) begin
            mid();
            if (OUT_VALID) begin
                expd = recv[7:0] ^ 8'h5A;
                chk("stream_tail_data", OUT_DATA, expd);
                recv++;
            end
            step();
        end
        mid();
        chk("stream_all_recv", recv, sent);
        chk("stream_end_count", COUNT, 0);
        step();

        // ---------------- random backpressure ----------------
        cerr = 0; colerr = 0; uerr = 0;
        for (int c = 0; c < 20000; c++) begin
            IN_VALID  = ($urandom_range(0, 1) == 1);
            OUT_READY = ($urandom_range(0, 3) != 0);
            IN_DATA   = 8'($urandom);
            mid();
            if (COUNT !== 14'(sb.size())) cerr++;
            if (MEM_CE0 && MEM_CE1 && (MEM_A0 == MEM_A1)) colerr++;
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) uerr++;
                else begin
                    expd = sb.pop_front();
                    chk("rand_data", OUT_DATA, expd);
                end
            end
            if (IN_VALID && IN_READY) sb.push_back(IN_DATA);
            step();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (int c = 0; c < 60; c++) begin
            mid();
            if (OUT_VALID) begin
                if (sb.size() == 0) uerr++;
                else begin
                    expd = sb.pop_front();
                    chk("rand_drain_data", OUT_DATA, expd);
                end
            end
            step();
        end
        mid();
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_count_errs", cerr, 0);
        chk("rand_collisions", colerr, 0);
        chk("rand_spurious_pops", uerr, 0);
        chk("rand_end_count", COUNT, 0);
        step();

        // ---------------- flush mid-read ----------------
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'h11;
        step();
        IN_DATA = 8'h22;
        step();
        IN_VALID = 1'b0;
        mid();
        chk("fl_fetch2_ce1", MEM_CE1, 1);
        step();
        CLR = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h77;
        mid();
        chk("fl_pre_count", COUNT, 2);
        chk("fl_pre_head", OUT_DATA, 8'h11);
        chk("fl_clr_in_ready", IN_READY, 0);
        chk("fl_clr_ce0", MEM_CE0, 0);
        chk("fl_clr_ce1", MEM_CE1, 0);
        step();
        CLR = 1'b0; IN_DATA = 8'h3C;
        mid();
        chk("fl_post_ovld", OUT_VALID, 0);
        chk("fl_post_count", COUNT, 0);
        chk("fl_post_ce0", MEM_CE0, 1);
        chk("fl_post_a0", MEM_A0, 0);
        step();
        IN_VALID = 1'b0;
        mid();
        chk("fl_c1_ce1", MEM_CE1, 1);
        chk("fl_c1_a1", MEM_A1, 0);
        chk("fl_c1_ovld", OUT_VALID, 0);
        step();
        mid();
        chk("fl_c2_ovld", OUT_VALID, 0);
        step();
        OUT_READY = 1'b1;
        mid();
        chk("fl_c3_ovld", OUT_VALID, 1);
        chk("fl_c3_data", OUT_DATA, 8'h3C);
        chk("fl_c3_count", COUNT, 1);
        step();
        mid();
        chk("fl_end_count", COUNT, 0);
        chk("fl_end_ovld", OUT_VALID, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_b_fifo_ctrl.md
# sram_b_fifo_ctrl

Valid/ready FIFO controller that turns an external 1w:1r banked SRAM (8192 x 8, 13-bit address, 1-cycle read latency) into a streaming queue. It sits directly upstream of the SRAM: it drives the write port (CE0/A0/D0/WE0/WEM0) and the read port (CE1/A1), and captures Q1. A 2-entry output buffer absorbs the read latency so the consumer sees full-throughput valid/ready semantics.

## Interface
- DEPTH_LOG2, 13, SRAM address width; SRAM depth = 2^DEPTH_LOG2
- WIDTH, 8, data width; equals SRAM word width and WEM width

- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- CLR  in  1  synchronous flush, active-high
- IN_VALID  in  1  producer has data
- IN_READY  out  1  controller accepts data
- IN_DATA  in  WIDTH  producer data
- OUT_VALID  out  1  head of queue valid
- OUT_READY  in  1  consumer takes head
- OUT_DATA  out  WIDTH  head of queue
- COUNT  out  DEPTH_LOG2+1  total words held
- MEM_CE0  out  1  SRAM write-port enable
- MEM_A0  out  DEPTH_LOG2  write address
- MEM_D0  out  WIDTH  write data
- MEM_WE0  out  1  write enable
- MEM_WEM0  out  WIDTH  write bit mask
- MEM_CE1  out  1  SRAM read-port enable
- MEM_A1  out  DEPTH_LOG2  read address
- MEM_Q1  in  WIDTH  read data, valid the cycle after MEM_CE1

## Operation
- State: wptr, rptr (DEPTH_LOG2 bits, wrap mod 2^DEPTH_LOG2), mem_cnt (0..DEPTH), rd_pend (0/1), 2-entry output buffer ob with ob_cnt (0..2).
- Push = IN_VALID & IN_READY. IN_READY = RSTN & !CLR & (mem_cnt != DEPTH), from registered state only; no bypass of the SRAM.
- On push: MEM_CE0=1, MEM_WE0=1, MEM_WEM0=all ones, MEM_A0=wptr, MEM_D0=IN_DATA (combinational); wptr++. Otherwise MEM_CE0, MEM_WE0, MEM_WEM0 = 0; MEM_A0, MEM_D0 = 0.
- Pop = OUT_VALID & OUT_READY; OUT_VALID = (ob_cnt != 0); OUT_DATA = ob head.
- Fetch = (mem_cnt != 0) & !CLR & (ob_cnt + rd_pend - pop < 2). On fetch: MEM_CE1=1, MEM_A1=rptr, rptr++, rd_pend<=1; else MEM_CE1=0, MEM_A1=0, rd_pend<=0.
- If rd_pend=1 and !CLR: MEM_Q1 written into ob tail that cycle.
- mem_cnt <= mem_cnt + push - fetch. ob_cnt <= ob_cnt + rd_pend - pop. Capture and pop in the same cycle keep order.
- COUNT = mem_cnt + rd_pend + ob_cnt; max DEPTH+2.
- Conflict freedom: fetch requires mem_cnt>0, so a same-cycle read and write never hit the same address (at mem_cnt=DEPTH, rptr==wptr but push is blocked).
- CLR: pointers, mem_cnt, rd_pend, ob_cnt <= 0; any MEM_Q1 returning the next cycle is discarded (rd_pend already 0). No push and no fetch in a CLR cycle.

## Timing
- Reset (RSTN low, asynchronous): all state 0; IN_READY=0, OUT_VALID=0, OUT_DATA=0, COUNT=0, all MEM_* outputs 0. IN_READY=1 in the first cycle after RSTN rises.
- Latency: push in cycle 0 -> mem_cnt=1, MEM_CE1 in cycle 1 -> MEM_Q1 in cycle 2, captured at end of cycle 2 -> OUT_VALID in cycle 3. Minimum push-to-OUT_VALID latency is 3 cycles.
- Throughput: 1 word/cycle in steady state (ob_cnt=1, rd_pend=1, pop=1 still fetches).
- Capacity: DEPTH words in SRAM + 2 in ob = DEPTH+2 accepted before IN_READY drops; IN_READY rises the cycle after a fetch frees a location.
- ob overflow impossible by the fetch rule; a pop from empty ob is impossible because OUT_VALID=0.

## Test plan
- Reset: hold RSTN low with IN_VALID=1 -> IN_READY=0, MEM_CE0=0, OUT_VALID=0, COUNT=0; after release IN_READY=1 next cycle.
- Single word: push 0xA5 in cycle 0 -> MEM_A0=0, MEM_WE0=1, MEM_WEM0=0xFF; MEM_CE1=1, MEM_A1=0 in cycle 1; OUT_VALID=1, OUT_DATA=0xA5 in cycle 3; pop -> COUNT=0.
- Fill and wrap: OUT_READY=0, push 0,1,2,... -> exactly 8194 accepted, COUNT=8194, IN_READY=0; then drain -> values in order, pointers wrap 8191->0, final COUNT=0.
- Streaming: IN_VALID=1 and OUT_READY=1 continuous with an incrementing pattern -> after 3 cycles, OUT_VALID stays 1 every cycle with no bubbles, COUNT steady at 3.
- Random backpressure: random IN_VALID/OUT_READY for 20k cycles -> scoreboard matches, no loss or duplication, MEM_A0 != MEM_A1 whenever MEM_CE0 and MEM_CE1 are both high.
- Flush mid-read: CLR in the cycle after a fetch (rd_pend=1, ob_cnt=1) -> next cycle OUT_VALID=0, COUNT=0, the returning MEM_Q1 is ignored; a new push then appears as the first output 3 cycles later.
